// File: rtl/mips16_pkg.sv
// rtl/mips16_pkg.sv - shared widths, flag indices and register names for the 16-bit MIPS datapath
package mips16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 8;

  // Bit positions inside the {N,C,Z} flag vector
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  localparam logic [ADDR_W-1:0] R0 = 3'd0;
  localparam logic [ADDR_W-1:0] R1 = 3'd1;
  localparam logic [ADDR_W-1:0] R2 = 3'd2;
  localparam logic [ADDR_W-1:0] R3 = 3'd3;
  localparam logic [ADDR_W-1:0] R4 = 3'd4;
  localparam logic [ADDR_W-1:0] R5 = 3'd5;
  localparam logic [ADDR_W-1:0] R6 = 3'd6;
  localparam logic [ADDR_W-1:0] R7 = 3'd7;

endpackage

// File: rtl/status_reg.sv
// rtl/status_reg.sv - small load-enable register with synchronous active-low clear
module status_reg #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Load new value when enabled, otherwise hold
  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  // State register; clear wins over load
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 8x16 register file with R0 hardwired to zero plus {N,C,Z} flag register
module alu_regfile
  import mips16_pkg::*;
#(
  parameter int DATA_W  = mips16_pkg::DATA_W,
  parameter int ADDR_W  = mips16_pkg::ADDR_W,
  parameter int NUM_DBG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] WA3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              FlagWE,
  input  logic              NegativeIn,
  input  logic              CarryIn,
  input  logic              ZeroIn,
  output logic [2:0]        Flags,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Entry 0 is never written after reset; reads of address 0 are forced to zero anyway
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [2:0]        flags_in;

  // Register array: reset clears everything, writes to R0 are dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (WE3 && (WA3 != '0)) begin
      regs_q[WA3] <= WD3;
    end
  end

  // Reads see current state only; no bypass from WD3 because WD3 is derived from RD1/RD2
  assign RD1 = (RA1 == '0) ? '0 : regs_q[RA1];
  assign RD2 = (RA2 == '0) ? '0 : regs_q[RA2];

  // Pack the ALU flag outputs into {N,C,Z} order
  always_comb begin
    flags_in         = '0;
    flags_in[FLAG_N] = NegativeIn;
    flags_in[FLAG_C] = CarryIn;
    flags_in[FLAG_Z] = ZeroIn;
  end

  status_reg #(.W(3)) u_flags (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (FlagWE),
    .d_i   (flags_in),
    .q_o   (Flags)
  );

  if (NUM_DBG > 0) begin : g_dbg
    assign DbgData = (DbgAddr == '0) ? '0 : regs_q[DbgAddr];
  end else begin : g_no_dbg
    assign DbgData = '0;
  end

endmodule

// File: tb/tb_alu_regfile.sv
// tb/tb_alu_regfile.sv - table-driven scoreboard bench for alu_regfile
module tb_alu_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  RA1, RA2, WA3, DbgAddr;
  logic [15:0] RD1, RD2, DbgData, wd_drv, WD3;
  logic        WE3, FlagWE, NegativeIn, CarryIn, ZeroIn;
  logic [2:0]  Flags;
  logic        alu_mode;

  // In alu_mode the write-back value comes straight from the read ports, like the real datapath
  assign WD3 = alu_mode ? (RD1 + RD2) : wd_drv;

  alu_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RA1        (RA1),
    .RA2        (RA2),
    .RD1        (RD1),
    .RD2        (RD2),
    .WE3        (WE3),
    .WA3        (WA3),
    .WD3        (WD3),
    .FlagWE     (FlagWE),
    .NegativeIn (NegativeIn),
    .CarryIn    (CarryIn),
    .ZeroIn     (ZeroIn),
    .Flags      (Flags),
    .DbgAddr    (DbgAddr),
    .DbgData    (DbgData)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          we;
    logic [2:0]  wa;
    logic [15:0] wd;
    bit          fwe;
    logic [2:0]  ncz;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [2:0]  da;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] ed;
    logic [2:0]  ef;
  } vec_t;

  typedef struct packed {
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] ed;
    logic [2:0]  ef;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad   = 0;
  logic [15:0] mdl [8];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one instruction cycle, check combinational outputs before the edge, then clock it
  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    string n;
    @(negedge clk);
    rst_n = v.rst; WE3 = v.we; WA3 = v.wa; wd_drv = v.wd; FlagWE = v.fwe;
    {NegativeIn, CarryIn, ZeroIn} = v.ncz;
    RA1 = v.ra1; RA2 = v.ra2; DbgAddr = v.da;
    sb_q.push_back('{e1: v.e1, e2: v.e2, ed: v.ed, ef: v.ef});
    nm_q.push_back(nm);
    #1;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      n = nm_q.pop_front();
      check({n, ".rd1"},   RD1,             e.e1);
      check({n, ".rd2"},   RD2,             e.e2);
      check({n, ".dbg"},   DbgData,         e.ed);
      check({n, ".flags"}, {13'd0, Flags},  {13'd0, e.ef});
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; WE3 = 1'b0; FlagWE = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  vec_t vecs [19];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          rst we wa  wd        fwe ncz     ra1 ra2 da  e1        e2        ed        ef
    vecs[0]  = '{1, 0, 0, 16'h0000, 0, 3'b000, 3, 5, 7, 16'h0000, 16'h0000, 16'h0000, 3'b000};
    vecs[1]  = '{1, 1, 3, 16'hBEEF, 0, 3'b000, 3, 5, 3, 16'h0000, 16'h0000, 16'h0000, 3'b000};
    vecs[2]  = '{1, 1, 5, 16'hBEEF, 0, 3'b000, 3, 5, 3, 16'hBEEF, 16'h0000, 16'hBEEF, 3'b000};
    vecs[3]  = '{0, 1, 4, 16'h1234, 1, 3'b111, 3, 5, 4, 16'hBEEF, 16'hBEEF, 16'h0000, 3'b000};
    vecs[4]  = '{1, 0, 0, 16'h0000, 0, 3'b000, 3, 5, 4, 16'h0000, 16'h0000, 16'h0000, 3'b000};
    vecs[5]  = '{1, 1, 2, 16'h00A5, 0, 3'b000, 2, 0, 2, 16'h0000, 16'h0000, 16'h0000, 3'b000};
    vecs[6]  = '{1, 1, 0, 16'hFFFF, 0, 3'b000, 2, 0, 0, 16'h00A5, 16'h0000, 16'h0000, 3'b000};
    vecs[7]  = '{1, 0, 0, 16'h0000, 0, 3'b000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'b000};
    vecs[8]  = '{1, 1, 6, 16'h1111, 0, 3'b000, 6, 2, 6, 16'h0000, 16'h00A5, 16'h0000, 3'b000};
    vecs[9]  = '{1, 1, 6, 16'h2222, 0, 3'b000, 6, 6, 6, 16'h1111, 16'h1111, 16'h1111, 3'b000};
    vecs[10] = '{1, 0, 0, 16'h0000, 0, 3'b000, 6, 6, 6, 16'h2222, 16'h2222, 16'h2222, 3'b000};
    vecs[11] = '{1, 1, 1, 16'h0007, 0, 3'b000, 1, 7, 1, 16'h0000, 16'h0000, 16'h0000, 3'b000};
    vecs[12] = '{1, 1, 7, 16'h8000, 0, 3'b000, 1, 7, 7, 16'h0007, 16'h0000, 16'h0000, 3'b000};
    vecs[13] = '{1, 0, 1, 16'h0009, 0, 3'b000, 1, 7, 7, 16'h0007, 16'h8000, 16'h8000, 3'b000};
    vecs[14] = '{1, 0, 0, 16'h0000, 0, 3'b000, 1, 7, 1, 16'h0007, 16'h8000, 16'h0007, 3'b000};
    vecs[15] = '{1, 0, 0, 16'h0000, 1, 3'b100, 1, 1, 0, 16'h0007, 16'h0007, 16'h0000, 3'b000};
    vecs[16] = '{1, 0, 0, 16'h0000, 0, 3'b011, 1, 1, 0, 16'h0007, 16'h0007, 16'h0000, 3'b100};
    vecs[17] = '{1, 1, 5, 16'h5555, 1, 3'b011, 5, 1, 0, 16'h0000, 16'h0007, 16'h0000, 3'b100};
    vecs[18] = '{1, 0, 0, 16'h0000, 0, 3'b000, 5, 1, 5, 16'h5555, 16'h0007, 16'h5555, 3'b011};

    alu_mode = 1'b0;
    rst_n = 1'b0; WE3 = 1'b0; WA3 = '0; wd_drv = '0; FlagWE = 1'b0;
    NegativeIn = 1'b0; CarryIn = 1'b0; ZeroIn = 1'b0;
    RA1 = '0; RA2 = '0; DbgAddr = '0;
    do_reset();

    for (int i = 0; i < 19; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Full sweep from a clean state, expectations from a small reference array
    do_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    for (int i = 1; i < 8; i++) begin
      v = '{1, 1, i[2:0], 16'h1000 + 16'(i), 0, 3'b000, i[2:0], 3'd0, i[2:0],
            mdl[i], 16'h0000, mdl[i], 3'b000};
      apply(v, $sformatf("sweep_wr%0d", i));
      mdl[i] = 16'h1000 + 16'(i);
    end
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        v = '{1, 0, 3'd0, 16'h0000, 0, 3'b000, a[2:0], b[2:0], b[2:0],
              mdl[a], mdl[b], mdl[b], 3'b000};
        apply(v, $sformatf("sweep_rd%0d_%0d", a, b));
      end
    end

    // ALU loop: R3 <= R1 + R2 with WD3 fed from the read ports
    @(negedge clk);
    alu_mode = 1'b1; RA1 = 3'd1; RA2 = 3'd2; WE3 = 1'b1; WA3 = 3'd3; DbgAddr = 3'd3;
    #1;
    check("loop.rd1_pre",  RD1,     16'h1001);
    check("loop.rd2_pre",  RD2,     16'h1002);
    check("loop.wd3",      WD3,     16'h2003);
    check("loop.r3_old",   DbgData, 16'h1003);
    @(posedge clk);
    @(negedge clk);
    alu_mode = 1'b0; WE3 = 1'b0; RA1 = 3'd3;
    #1;
    check("loop.r3_new",   RD1,     16'h2003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
